// File: rtl/mux_if.sv
// Lane-side and stream-side signals of the 4:1 round-robin byte multiplexer.
// master is the neighbour that drives the lanes and observes the stream; slave is the mux.
interface mux_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in0;
    logic [WIDTH-1:0] data_in1;
    logic [WIDTH-1:0] data_in2;
    logic [WIDTH-1:0] data_in3;
    logic             valid_in0;
    logic             valid_in1;
    logic             valid_in2;
    logic             valid_in3;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic [7:0]       control;

    modport master (
        output data_in0, data_in1, data_in2, data_in3,
        output valid_in0, valid_in1, valid_in2, valid_in3,
        input  data_out, valid_out, control
    );

    modport slave (
        input  data_in0, data_in1, data_in2, data_in3,
        input  valid_in0, valid_in1, valid_in2, valid_in3,
        output data_out, valid_out, control
    );
endinterface

// File: rtl/mux.sv
// Round-robin time-multiplexer: four quarter-rate byte lanes onto one full-rate
// stream, with a control word (lane index, frame start, valid) for the demux.
module mux #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_BYTE = '0
) (
    input  logic clk,
    input  logic reset,
    mux_if.slave bus
);

    logic [1:0]       cnt;
    logic [WIDTH-1:0] fd [4];
    logic             fv [4];
    logic [WIDTH-1:0] lane_data  [4];
    logic             lane_valid [4];

    always_comb begin
        lane_data[0]  = bus.data_in0;
        lane_data[1]  = bus.data_in1;
        lane_data[2]  = bus.data_in2;
        lane_data[3]  = bus.data_in3;
        lane_valid[0] = bus.valid_in0;
        lane_valid[1] = bus.valid_in1;
        lane_valid[2] = bus.valid_in2;
        lane_valid[3] = bus.valid_in3;
    end

    // NOTE: non-blocking assignments make every read below see pre-edge state,
    // so the lane 3 slot at cnt==3 emits the old frame while the new one is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= 2'd0;
            bus.data_out  <= IDLE_BYTE;
            bus.valid_out <= 1'b0;
            bus.control   <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                fd[i] <= '0;
                fv[i] <= 1'b0;
            end
        end else begin
            cnt <= cnt + 2'd1;

            if (cnt == 2'd3) begin
                for (int i = 0; i < 4; i++) begin
                    fd[i] <= lane_data[i];
                    fv[i] <= lane_valid[i];
                end
            end

            bus.valid_out <= fv[cnt];
            bus.data_out  <= fv[cnt] ? fd[cnt] : IDLE_BYTE;
            bus.control   <= {4'b0000, fv[cnt], (cnt == 2'd0), cnt};
        end
    end

endmodule

// File: tb/tb_mux.sv
// Directed self-checking bench for the round-robin byte multiplexer.
module tb_mux;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mux_if #(.WIDTH(8)) bus ();

    mux #(.WIDTH(8), .IDLE_BYTE(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic v, input logic [7:0] c);
        check8({tag, ".data"}, bus.data_out, d);
        check8({tag, ".valid"}, {7'd0, bus.valid_out}, {7'd0, v});
        check8({tag, ".control"}, bus.control, c);
    endtask

    task automatic set_lanes(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3,
                             input logic [3:0] v);
        bus.data_in0  = d0;
        bus.data_in1  = d1;
        bus.data_in2  = d2;
        bus.data_in3  = d3;
        bus.valid_in0 = v[0];
        bus.valid_in1 = v[1];
        bus.valid_in2 = v[2];
        bus.valid_in3 = v[3];
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_lanes(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        repeat (3) tick();
        check_out("reset", 8'h00, 1'b0, 8'h00);
        reset = 1'b0;

        // Edges 1..8 after release: all lanes invalid, control cycles 04,01,02,03.
        for (int k = 0; k < 8; k++) begin
            tick();
            case (k % 4)
                0: check_out("idle_l0", 8'h00, 1'b0, 8'h04);
                1: check_out("idle_l1", 8'h00, 1'b0, 8'h01);
                2: check_out("idle_l2", 8'h00, 1'b0, 8'h02);
                default: check_out("idle_l3", 8'h00, 1'b0, 8'h03);
            endcase
        end

        // Frame A presented for edges 9..12, captured at edge 12.
        set_lanes(8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'b1111);
        tick(); check_out("pre_a_l0", 8'h00, 1'b0, 8'h04);
        tick(); check_out("pre_a_l1", 8'h00, 1'b0, 8'h01);
        tick(); check_out("pre_a_l2", 8'h00, 1'b0, 8'h02);
        tick(); check_out("pre_a_l3", 8'h00, 1'b0, 8'h03);

        // Frame B (lanes 1,3 invalid with FF data) for capture at edge 16.
        set_lanes(8'h11, 8'hFF, 8'h33, 8'hFF, 4'b0101);
        tick(); check_out("a_l0", 8'hA0, 1'b1, 8'h0C);
        tick(); check_out("a_l1", 8'hB1, 1'b1, 8'h09);
        tick(); check_out("a_l2", 8'hC2, 1'b1, 8'h0A);
        tick(); check_out("a_l3", 8'hD3, 1'b1, 8'h0B);

        // Frame C: lane 0 changes after the cnt=0 edge, seen first on the cnt=1 edge.
        set_lanes(8'h77, 8'h22, 8'h23, 8'h5A, 4'b1111);
        tick(); check_out("b_l0", 8'h11, 1'b1, 8'h0C);
        bus.data_in0 = 8'h78;
        tick(); check_out("b_l1", 8'h00, 1'b0, 8'h01);
        tick(); check_out("b_l2", 8'h33, 1'b1, 8'h0A);
        tick(); check_out("b_l3", 8'h00, 1'b0, 8'h03);

        // Frame D captured on the same edge that emits frame C lane 3 (5A).
        set_lanes(8'h44, 8'h55, 8'h66, 8'h6B, 4'b1111);
        tick(); check_out("c_l0", 8'h78, 1'b1, 8'h0C);
        tick(); check_out("c_l1", 8'h22, 1'b1, 8'h09);
        tick(); check_out("c_l2", 8'h23, 1'b1, 8'h0A);
        tick(); check_out("c_l3", 8'h5A, 1'b1, 8'h0B);
        tick(); check_out("d_l0", 8'h44, 1'b1, 8'h0C);
        tick(); check_out("d_l1", 8'h55, 1'b1, 8'h09);
        tick(); check_out("d_l2", 8'h66, 1'b1, 8'h0A);
        tick(); check_out("d_l3", 8'h6B, 1'b1, 8'h0B);

        // Frame D recaptured; reset after lanes 0 and 1 are out.
        tick(); check_out("d2_l0", 8'h44, 1'b1, 8'h0C);
        tick(); check_out("d2_l1", 8'h55, 1'b1, 8'h09);
        reset = 1'b1;
        tick(); check_out("mid_reset", 8'h00, 1'b0, 8'h00);
        reset = 1'b0;
        tick(); check_out("rst_l0", 8'h00, 1'b0, 8'h04);
        tick(); check_out("rst_l1", 8'h00, 1'b0, 8'h01);
        tick(); check_out("rst_l2", 8'h00, 1'b0, 8'h02);
        tick(); check_out("rst_l3", 8'h00, 1'b0, 8'h03);
        tick(); check_out("post_rst_l0", 8'h44, 1'b1, 8'h0C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux.md
Name: mux

Overview:
- Upstream neighbour of the demux; produces its `valid_in`, `data_in` and `control`.
- Collects four byte lanes that each run at one quarter of the clock rate (250 kHz lanes on the 1 MHz `clk`).
- Time-multiplexes them round-robin onto one byte stream at the full clock rate: one lane per cycle, fixed order 0,1,2,3.
- Emits a per-byte valid and a control word carrying lane index and frame start, so the demux can route bytes back to their lanes.

Parameters:
- WIDTH, 8, byte width of every lane and of `data_out`.
- IDLE_BYTE, 8'h00, value driven on `data_out` whenever the selected lane is not valid.

Ports:
- clk  input  1  single system clock (1 MHz); all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in0  input  WIDTH  lane 0 byte.
- data_in1  input  WIDTH  lane 1 byte.
- data_in2  input  WIDTH  lane 2 byte.
- data_in3  input  WIDTH  lane 3 byte.
- valid_in0  input  1  lane 0 byte valid.
- valid_in1  input  1  lane 1 byte valid.
- valid_in2  input  1  lane 2 byte valid.
- valid_in3  input  1  lane 3 byte valid.
- data_out  output  WIDTH  serialized byte (registered).
- valid_out  output  1  `data_out` valid (registered).
- control  output  8  [1:0] lane index of current `data_out`; [2] frame start (lane 0 slot); [3] copy of `valid_out`; [7:4] always 0.

Behaviour:
- Clocking and reset:
  - One clock `clk`; reset is synchronous and active-high.
  - Everything is sampled on the rising edge of `clk`; `reset` has priority over all other logic.
- Reset values:
  - slot counter `cnt` = 0.
  - frame registers `fd[0..3]` = 0 and `fv[0..3]` = 0.
  - `data_out` = IDLE_BYTE, `valid_out` = 0, `control` = 8'h00.
- Slot counter:
  - `cnt` is 2 bits and increments by 1 on every non-reset edge.
  - Wraps 3 -> 0 with no gaps; there is no enable.
- Capture:
  - On an edge where pre-edge `cnt` = 3: `fd[i]` <= `data_in_i` and `fv[i]` <= `valid_in_i` for all four lanes simultaneously.
  - Lane inputs are ignored on all other edges.
  - Upstream lanes hold each byte for 4 clocks, so exactly one sample is taken per lane byte.
- Output, on every non-reset edge with L = pre-edge `cnt`:
  - `valid_out` <= `fv[L]` (pre-edge).
  - `data_out` <= `fv[L]` ? `fd[L]` : IDLE_BYTE.
  - `control` <= {4'b0, `fv[L]`, (L==0), L}.
- Same-edge ordering:
  - At `cnt` = 3 the lane 3 output uses the pre-edge frame (the current frame).
  - The new capture becomes visible from the next edge.
- Latency:
  - Inputs are captured at edge E.
  - Lane i appears on outputs after edge E+1+i and is held exactly one cycle.
  - Lane 0 therefore appears 1 cycle after capture and lane 3 appears 4 cycles after capture.
- First frame:
  - The first capture is at the 4th edge after reset deasserts.
  - The 4 output cycles before that carry `fv` = 0: `valid_out` = 0, `data_out` = IDLE_BYTE.
  - `control[1:0]` still cycles 0,1,2,3 and `control[2]` pulses in the lane 0 slot.
- Invalid lanes:
  - An invalid lane occupies its slot with `valid_out` = 0 and `data_out` = IDLE_BYTE.
  - Slots are never skipped or compacted.
- Reset mid-frame:
  - On the reset edge all state returns to reset values and any partially output frame is discarded.
  - After deassertion the slot sequence restarts at lane 0.
- Other rules:
  - No backpressure; the output stream is unconditional.
  - `control[7:4]` is constant 0.
  - No combinational path from any input to any output.

Test Plan:
- Reset held 3 cycles, then released, all lanes invalid -> `valid_out` = 0 and `data_out` = 8'h00 every cycle; `control` sequence 8'h04, 8'h01, 8'h02, 8'h03 repeating.
- Lanes 8'hA0, 8'hB1, 8'hC2, 8'hD3, all valid, held 4 cycles, aligned to capture -> after capture edge, output 8'hA0, 8'hB1, 8'hC2, 8'hD3 on consecutive cycles with `valid_out` = 1; `control` = 8'h0C, 8'h09, 8'h0A, 8'h0B.
- Lanes 0 and 2 valid (8'h11, 8'h33), lanes 1 and 3 invalid with data 8'hFF -> output 8'h11, 8'h00, 8'h33, 8'h00; `valid_out` = 1, 0, 1, 0.
- Lane data changed on a non-capture edge (`cnt` = 1) -> output unchanged until the next capture at `cnt` = 3.
- Continuous frames with lane 3 = 8'h5A then 8'h6B -> at the shared edge, 8'h5A is output while 8'h6B is captured; 8'h6B appears 4 cycles later.
- `reset` asserted after lanes 0 and 1 of a frame have been output -> next cycle all outputs are reset values; after release, lane 0 slot (`control` = 8'h04) appears on the first edge.
